// File: rtl/nts_dispatcher_backend.sv
// nts_dispatcher_backend
// Reads one completed frame out of the dispatcher frame store and streams it
// to the NTS engine as 64-bit words with keep/last markers, then releases the
// buffer with a one-cycle read-discard pulse. A FIFO underrun mid-frame flushes
// the pipeline and pulses o_rx_abort instead of emitting a truncated frame.
//
// Build option: define NTS_DISPATCHER_BACKEND_STATS_EN to implement the two
// 32-bit statistics counters; otherwise both stat outputs are tied to zero.
module nts_dispatcher_backend #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_dispatch_packet_available,
    output logic                  o_dispatch_packet_read_discard,
    input  logic [ADDR_WIDTH-1:0] i_dispatch_counter,
    input  logic [7:0]            i_dispatch_data_valid,
    input  logic                  i_dispatch_fifo_empty,
    output logic                  o_dispatch_fifo_rd_en,
    input  logic [63:0]           i_dispatch_fifo_rd_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic [63:0]           o_rx_data,
    output logic [7:0]            o_rx_keep,
    output logic                  o_rx_last,
    output logic                  o_rx_abort,
    output logic [31:0]           o_stat_packets,
    output logic [31:0]           o_stat_aborts
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LATCH      = 3'd1;
    localparam logic [2:0] ST_READ       = 3'd2;
    localparam logic [2:0] ST_DRAIN      = 3'd3;
    localparam logic [2:0] ST_DISCARD    = 3'd4;
    localparam logic [2:0] ST_WAIT_CLEAR = 3'd5;

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [ADDR_WIDTH-1:0] last_addr_reg;
    logic [7:0]            last_keep_reg;
    // One extra bit so a full frame (last_addr all ones) ends at 2^ADDR_WIDTH
    // instead of wrapping back to zero.
    logic [ADDR_WIDTH:0]   idx_reg;
    logic                  inflight_reg;
    logic                  inflight_last_reg;
    logic [1:0]            occ_reg;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic                  abort_reg;

    logic                  pop;
    logic                  push;
    logic [1:0]            occ_after_pop;
    logic [1:0]            committed;
    logic                  pending;
    logic                  rd_en;
    logic                  issue_last;
    logic                  underrun;

    logic [63:0]           entry_data [2];
    logic [7:0]            entry_keep [2];
    logic                  entry_last [2];

    // Handshake and read-issue decode. Credit counts the slot freed by a pop
    // this cycle so a steady ready stream sustains one word per cycle while
    // buffered plus in-flight words never exceed the two buffer entries.
    always_comb begin
        pop           = o_rx_valid & i_rx_ready;
        push          = inflight_reg;
        occ_after_pop = occ_reg - {1'b0, pop};
        committed     = occ_after_pop + {1'b0, inflight_reg};
        pending       = (idx_reg <= {1'b0, last_addr_reg});
        rd_en         = (state_reg == ST_READ) && pending &&
                        !i_dispatch_fifo_empty && (committed < 2'd2);
        issue_last    = rd_en && (idx_reg == {1'b0, last_addr_reg});
        underrun      = (state_reg == ST_READ) && pending && i_dispatch_fifo_empty;
    end

    // Next-state logic for the frame readout sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_dispatch_packet_available && !i_dispatch_fifo_empty)
                    state_next = ST_LATCH;
            end
            ST_LATCH: state_next = ST_READ;
            ST_READ: begin
                if (underrun)
                    state_next = ST_DISCARD;
                else if (issue_last)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((occ_after_pop == 2'd0) && !inflight_reg)
                    state_next = ST_DISCARD;
            end
            ST_DISCARD: state_next = ST_WAIT_CLEAR;
            ST_WAIT_CLEAR: begin
                if (!i_dispatch_packet_available)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus per-frame parameters latched on entry.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_reg     <= ST_IDLE;
            last_addr_reg <= '0;
            last_keep_reg <= 8'h00;
            idx_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_LATCH) begin
                last_addr_reg <= i_dispatch_counter;
                last_keep_reg <= (i_dispatch_data_valid == 8'h00) ? 8'hFF
                                                                  : i_dispatch_data_valid;
                idx_reg       <= '0;
            end else if (rd_en) begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // In-flight tracking: a read issued this cycle returns data next cycle.
    // An underrun drops whatever is still in flight.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_reg      <= rd_en & ~underrun;
            inflight_last_reg <= issue_last;
        end
    end

    // Output buffer bookkeeping; an underrun empties it so nothing partial
    // reaches the engine after the abort.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            occ_reg    <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else if (underrun) begin
            occ_reg    <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Buffer entries: only the non-head slot is ever written while the head
    // is waiting, so the presented word stays stable under backpressure.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [63:0] data_reg;
        logic [7:0]  keep_reg;
        logic        last_reg;

        // Capture the returning FIFO word into this slot when it is the target.
        always_ff @(posedge i_clk or posedge i_areset) begin
            if (i_areset) begin
                data_reg <= 64'd0;
                keep_reg <= 8'h00;
                last_reg <= 1'b0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= i_dispatch_fifo_rd_data;
                keep_reg <= inflight_last_reg ? last_keep_reg : 8'hFF;
                last_reg <= inflight_last_reg;
            end
        end

        assign entry_data[gi] = data_reg;
        assign entry_keep[gi] = keep_reg;
        assign entry_last[gi] = last_reg;
    end

    // Abort is registered off the underrun so it lands in the cycle the
    // flushed buffer first shows empty, never alongside a valid word.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset)
            abort_reg <= 1'b0;
        else
            abort_reg <= underrun;
    end

`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
    logic [31:0] stat_packets_reg;
    logic [31:0] stat_aborts_reg;
    logic        packet_done;

    assign packet_done = (state_reg == ST_DRAIN) && (state_next == ST_DISCARD);

    // Frame and abort counters, wrapping naturally at 32 bits.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            stat_packets_reg <= 32'd0;
            stat_aborts_reg  <= 32'd0;
        end else begin
            if (packet_done)
                stat_packets_reg <= stat_packets_reg + 32'd1;
            if (underrun)
                stat_aborts_reg <= stat_aborts_reg + 32'd1;
        end
    end

    assign o_stat_packets = stat_packets_reg;
    assign o_stat_aborts  = stat_aborts_reg;
`else
    assign o_stat_packets = 32'd0;
    assign o_stat_aborts  = 32'd0;
`endif

    assign o_dispatch_fifo_rd_en          = rd_en;
    assign o_dispatch_packet_read_discard = (state_reg == ST_DISCARD);
    assign o_rx_valid                     = (occ_reg != 2'd0);
    assign o_rx_data                      = entry_data[rd_ptr_reg];
    assign o_rx_keep                      = entry_keep[rd_ptr_reg];
    assign o_rx_last                      = entry_last[rd_ptr_reg];
    assign o_rx_abort                     = abort_reg;

endmodule

// File: tb/tb_nts_dispatcher_backend.sv
// Directed testbench for nts_dispatcher_backend (ADDR_WIDTH=4 so a full
// 16-word frame is reachable). A small FIFO model feeds read data one cycle
// after rd_en; a negedge monitor records accepted words and pulse counts.
module tb_nts_dispatcher_backend;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          available = 1'b0;
    logic          discard;
    logic [AW-1:0] counter = '0;
    logic [7:0]    data_valid = 8'h00;
    logic          fifo_empty;
    logic          rd_en;
    logic [63:0]   rd_data = 64'd0;
    logic          valid;
    logic          ready = 1'b0;
    logic [63:0]   data;
    logic [7:0]    keep;
    logic          last;
    logic          abort;
    logic [31:0]   stat_packets;
    logic [31:0]   stat_aborts;

    int checks = 0;
    int errors = 0;

    // FIFO model: initial block writes via wr_cnt, reader process owns rd_cnt.
    logic [63:0] fifo_mem [64];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        fifo_flush = 1'b0;

    // Monitor state.
    int          rd_tot = 0, acc_cnt = 0, disc_cnt = 0, abort_cnt = 0, last_cnt = 0;
    int          stab_err = 0, both_err = 0, max_out = 0;
    logic [63:0] acc_d [256];
    logic [7:0]  acc_k [256];
    logic        acc_l [256];
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [63:0] pd = 64'd0;
    logic [7:0]  pk = 8'h00;

    int ready_mode = 0;
    int tog_phase  = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_cnt == wr_cnt);

    nts_dispatcher_backend #(.ADDR_WIDTH(AW)) dut (
        .i_clk                          (clk),
        .i_areset                       (areset),
        .i_dispatch_packet_available    (available),
        .o_dispatch_packet_read_discard (discard),
        .i_dispatch_counter             (counter),
        .i_dispatch_data_valid          (data_valid),
        .i_dispatch_fifo_empty          (fifo_empty),
        .o_dispatch_fifo_rd_en          (rd_en),
        .i_dispatch_fifo_rd_data        (rd_data),
        .o_rx_valid                     (valid),
        .i_rx_ready                     (ready),
        .o_rx_data                      (data),
        .o_rx_keep                      (keep),
        .o_rx_last                      (last),
        .o_rx_abort                     (abort),
        .o_stat_packets                 (stat_packets),
        .o_stat_aborts                  (stat_aborts)
    );

    always @(posedge clk) begin
        if (fifo_flush)
            rd_cnt <= wr_cnt;
        else if (rd_en && (rd_cnt != wr_cnt)) begin
            rd_data <= fifo_mem[rd_cnt % 64];
            rd_cnt  <= rd_cnt + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: ready = 1'b0;
            1: ready = 1'b1;
            default: begin
                ready     = (tog_phase == 0) || (tog_phase == 3);
                tog_phase = (tog_phase + 1) % 4;
            end
        endcase
    end

    always @(negedge clk) begin
        if (areset) begin
            pv = 1'b0;
        end else begin
            if (rd_en) rd_tot++;
            if (discard) disc_cnt++;
            if (abort) abort_cnt++;
            if (abort && valid) both_err++;
            if (pv && !pr && (!valid || data !== pd || keep !== pk || last !== pl))
                stab_err++;
            if (valid && ready) begin
                acc_d[acc_cnt % 256] = data;
                acc_k[acc_cnt % 256] = keep;
                acc_l[acc_cnt % 256] = last;
                if (last) last_cnt++;
                acc_cnt++;
            end
            if (rd_tot - acc_cnt > max_out) max_out = rd_tot - acc_cnt;
            pv = valid; pr = ready; pd = data; pk = keep; pl = last;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n, input logic [63:0] seed);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_cnt % 64] = seed + 64'(i);
            wr_cnt++;
        end
    endtask

    task automatic wait_discard(input int target, input string tag);
        for (int i = 0; i < 400 && disc_cnt < target; i++) step();
        chk({tag, "_discard_seen"}, 64'(disc_cnt), 64'(target));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, "_discard"}, 64'(discard), 64'd0);
        chk({tag, "_valid"}, 64'(valid), 64'd0);
        chk({tag, "_data"}, data, 64'd0);
        chk({tag, "_keep"}, 64'(keep), 64'd0);
        chk({tag, "_last"}, 64'(last), 64'd0);
        chk({tag, "_abort"}, 64'(abort), 64'd0);
        chk({tag, "_stat_packets"}, 64'(stat_packets), 64'd0);
        chk({tag, "_stat_aborts"}, 64'(stat_aborts), 64'd0);
    endtask

    // Runs one frame; optionally holds available high for `hold` cycles after
    // discard with the next frame's words already queued in the FIFO.
    task automatic run_frame(input string tag, input int n, input logic [7:0] dv,
                             input logic [7:0] exp_last_keep, input logic [63:0] seed,
                             input bit preloaded, input int hold, input logic [63:0] next_seed);
        int b_acc, b_rd, b_disc, b_last, rd_hold;
        b_acc = acc_cnt; b_rd = rd_tot; b_disc = disc_cnt; b_last = last_cnt;
        if (!preloaded) load_words(n, seed);
        counter    = AW'(n - 1);
        data_valid = dv;
        available  = 1'b1;
        wait_discard(b_disc + 1, tag);
        if (hold > 0) begin
            load_words(n, next_seed);
            rd_hold = rd_tot;
            repeat (hold) step();
            chk({tag, "_no_relatch"}, 64'(rd_tot - rd_hold), 64'd0);
        end
        available = 1'b0;
        step();
        step();
        chk({tag, "_rd_en_count"}, 64'(rd_tot - b_rd), 64'(n));
        chk({tag, "_word_count"}, 64'(acc_cnt - b_acc), 64'(n));
        chk({tag, "_discard_count"}, 64'(disc_cnt - b_disc), 64'd1);
        chk({tag, "_last_count"}, 64'(last_cnt - b_last), 64'd1);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), acc_d[(b_acc + i) % 256], seed + 64'(i));
            chk($sformatf("%s_keep%0d", tag, i), 64'(acc_k[(b_acc + i) % 256]),
                (i == n - 1) ? 64'(exp_last_keep) : 64'hFF);
            chk($sformatf("%s_last%0d", tag, i), 64'(acc_l[(b_acc + i) % 256]),
                (i == n - 1) ? 64'd1 : 64'd0);
        end
    endtask

    int exp_pk;
    int exp_ab;
    int b_acc, b_rd, b_disc, b_last, b_abort;

    initial begin
        // Reset state.
        repeat (3) step();
        check_outputs_zero("reset");
        areset = 1'b0;
        step();

        // 3-word frame, ready held high.
        ready_mode = 1;
        run_frame("f3", 3, 8'h0F, 8'h0F, 64'hA000_0000_0000_0000, 1'b0, 0, 64'd0);
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
        exp_pk = 1;
`else
        exp_pk = 0;
`endif
        chk("f3_stat_packets", 64'(stat_packets), 64'(exp_pk));

        // Same frame with ready pattern 1,0,0,1.
        ready_mode = 2;
        run_frame("f3_stall", 3, 8'h0F, 8'h0F, 64'hB000_0000_0000_0100, 1'b0, 0, 64'd0);
        chk("stall_stability", 64'(stab_err), 64'd0);

        // Full 16-word frame, data_valid 0 latched as 0xFF.
        run_frame("f16", 16, 8'h00, 8'hFF, 64'hC000_0000_0000_1000, 1'b0, 0, 64'd0);
        chk("max_outstanding_le2", 64'(max_out <= 2), 64'd1);
        chk("stall_stability_f16", 64'(stab_err), 64'd0);

        // Underrun: 4-word frame, only 2 words ever present in the FIFO.
        ready_mode = 1;
        b_acc = acc_cnt; b_rd = rd_tot; b_disc = disc_cnt; b_last = last_cnt; b_abort = abort_cnt;
        load_words(2, 64'hD000_0000_0000_2000);
        counter    = AW'(3);
        data_valid = 8'h3F;
        available  = 1'b1;
        wait_discard(b_disc + 1, "abort");
        available = 1'b0;
        step();
        step();
        chk("abort_pulses", 64'(abort_cnt - b_abort), 64'd1);
        chk("abort_no_last", 64'(last_cnt - b_last), 64'd0);
        chk("abort_rd_en_count", 64'(rd_tot - b_rd), 64'd2);
        chk("abort_discard_count", 64'(disc_cnt - b_disc), 64'd1);
        chk("abort_valid_overlap", 64'(both_err), 64'd0);
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
        exp_pk = 3;
        exp_ab = 1;
`else
        exp_pk = 0;
        exp_ab = 0;
`endif
        chk("abort_stat_packets", 64'(stat_packets), 64'(exp_pk));
        chk("abort_stat_aborts", 64'(stat_aborts), 64'(exp_ab));

        // available held after discard; second frame read once it drops.
        run_frame("hold_a", 2, 8'h01, 8'h01, 64'hE000_0000_0000_3000, 1'b0, 3,
                  64'hE100_0000_0000_3100);
        run_frame("hold_b", 2, 8'h07, 8'h07, 64'hE100_0000_0000_3100, 1'b1, 0, 64'd0);

        // Reset mid-READ with ready low so the frame is stuck part way.
        ready_mode = 0;
        b_rd = rd_tot;
        load_words(8, 64'hF000_0000_0000_4000);
        counter    = AW'(7);
        data_valid = 8'hFF;
        available  = 1'b1;
        for (int i = 0; i < 50 && rd_tot < b_rd + 2; i++) step();
        chk("rst_reached_read", 64'(rd_tot - b_rd), 64'd2);
        step();
        b_disc = disc_cnt; b_abort = abort_cnt;
        areset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        available  = 1'b0;
        fifo_flush = 1'b1;
        step();
        fifo_flush = 1'b0;
        step();
        areset = 1'b0;
        step();
        chk("midreset_no_discard", 64'(disc_cnt - b_disc), 64'd0);
        chk("midreset_no_abort", 64'(abort_cnt - b_abort), 64'd0);

        // Single-word frame after reset.
        ready_mode = 1;
        run_frame("single", 1, 8'h03, 8'h03, 64'h1234_5678_9ABC_DEF0, 1'b0, 0, 64'd0);
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
        exp_pk = 1;
`else
        exp_pk = 0;
`endif
        chk("single_stat_packets", 64'(stat_packets), 64'(exp_pk));
        chk("final_valid_overlap", 64'(both_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nts_dispatcher_backend.md
# nts_dispatcher_backend

Drains one completed frame from the dispatcher's double-buffered frame store and presents it to the NTS engine as a 64-bit valid/ready word stream with byte-keep and last markers. It sits directly downstream of the dispatcher front end: it sees the packet-available/counter/data-valid status and uses the read-enable/read-data FIFO port. After the last word is accepted, it releases the buffer with a one-cycle read-discard pulse.

## Interface
- ADDR_WIDTH, 8: address width of the frame buffer; a frame holds up to 2^ADDR_WIDTH words.
- i_clk  in  1  clock
- i_areset  in  1  reset; asynchronous, active-high.
- i_dispatch_packet_available  in  1  a complete frame is ready for readout.
- o_dispatch_packet_read_discard  out  1  one-cycle pulse that releases the buffer.
- i_dispatch_counter  in  ADDR_WIDTH  index of the last word (word count minus 1).
- i_dispatch_data_valid  in  8  byte-valid mask of the last word.
- i_dispatch_fifo_empty  in  1  FIFO empty flag.
- o_dispatch_fifo_rd_en  out  1  read strobe; one word per pulse.
- i_dispatch_fifo_rd_data  in  64  read data, valid the cycle after rd_en.
- o_rx_valid / i_rx_ready  out / in  1 / 1  stream handshake to the engine.
- o_rx_data  out  64  stream word.
- o_rx_keep  out  8  byte-valid mask; 0xFF except on the last word.
- o_rx_last  out  1  marks the final word of the frame.
- o_rx_abort  out  1  one-cycle pulse; the engine drops the partial frame.
- o_stat_packets  out  32  count of frames completed.
- o_stat_aborts  out  32  count of underrun aborts.

## Operation
- State machine with states IDLE, LATCH, READ, DRAIN, DISCARD, WAIT_CLEAR.
- **IDLE**
  - Moves to LATCH when available=1 and fifo_empty=0.
- **LATCH** (one cycle)
  - Captures last_addr from i_dispatch_counter.
  - Captures last_keep from i_dispatch_data_valid; a value of 0x00 is latched as 0xFF.
  - Clears issue index idx, which is ADDR_WIDTH+1 bits wide so last_addr = all-ones cannot wrap.
  - Goes to READ.
- **READ**
  - Asserts rd_en when idx ≤ last_addr and (buffer occupancy + words in flight) < 2.
  - Each rd_en increments idx.
  - The returned word is pushed into a 2-entry output buffer, tagged last when its index equals last_addr.
  - Goes to DRAIN once the last-index rd_en has been issued.
- **DRAIN**
  - Waits until the output buffer is empty and no read is in flight, then goes to DISCARD.
- **DISCARD**
  - o_dispatch_packet_read_discard=1 for exactly one cycle.
  - Goes to WAIT_CLEAR.
- **WAIT_CLEAR**
  - Waits for available=0, then goes to IDLE; this prevents re-reading a stale frame.
- **Underrun**
  - Triggered by fifo_empty=1 in READ while idx ≤ last_addr and no rd_en is issued that cycle.
  - The output buffer and in-flight word are flushed (not presented).
  - o_rx_abort is pulsed and o_stat_aborts incremented.
  - Goes to DISCARD.
- **Output buffer**
  - The head word drives o_rx_*.
  - It pops when o_rx_valid & i_rx_ready.
  - A push and a pop in the same cycle keep occupancy unchanged.
- o_rx_data/keep/last must stay stable while o_rx_valid=1 and i_rx_ready=0.
- o_stat_packets increments on the DRAIN→DISCARD transition only; abort-path DISCARDs do not count.
- Both stat counters wrap modulo 2^32.

## Timing
- Reset values of all outputs are 0: rd_en, read_discard, rx_valid, rx_data, rx_keep, rx_last, rx_abort, both stats.
- Internal state on reset: IDLE, buffer empty.
- Reset mid-frame abandons the frame silently, with no abort pulse.
- Read latency: rd_en at cycle t, data captured at t+1, and o_rx_valid can be 1 at t+2.
- Sustained throughput is 1 word/cycle while i_rx_ready=1.
- Minimum frame overhead is 5 cycles:
  - 1 cycle IDLE→LATCH;
  - 1 cycle LATCH;
  - 2-cycle pipeline tail;
  - 1 cycle DISCARD.
- A single-word frame (last_addr=0) gives one rd_en, then one word with last=1 and keep=last_keep.
- o_rx_abort and o_rx_valid are never 1 in the same cycle.

## Configuration
- NTS_DISPATCHER_BACKEND_STATS_EN
  - Defined: both 32-bit counters are implemented as described.
  - Undefined: o_stat_packets and o_stat_aborts are tied to 0 and no counter flops are inferred.
  - Ports exist in both builds.

## Test plan
- 3-word frame (counter=2, data_valid=0x0F), ready held 1: exactly 3 rd_en pulses, 3 words in order; keep 0xFF, 0xFF, 0x0F; last on word 3 only; one discard pulse; stats packets=1.
- Same frame with ready toggling 1,0,0,1…: no word lost or duplicated; output stable while stalled; never more than 2 words buffered or in flight.
- Full frame, ADDR_WIDTH=4 and counter=15: exactly 16 words; last on word 16; idx does not wrap.
- fifo_empty forced to 1 after 2 of 4 reads: o_rx_abort pulses once, no last-flagged word is emitted, discard pulses once, aborts=1, packets=0.
- available held 1 for 3 cycles after discard: no new LATCH until it falls; a second frame is then read normally.
- i_areset asserted mid-READ: all outputs 0 at once, no discard or abort pulse; the next frame after release is read correctly.
